// File: rtl/seg_display_scheduler_if.sv
// Requester/display bundle for the shared two-digit 7-segment scheduler.
interface seg_display_scheduler_if #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned VALUE_W = 8
);
    logic [N_REQ-1:0]         i_Req;
    logic [N_REQ*VALUE_W-1:0] i_Value;
    logic [N_REQ-1:0]         o_Ack;
    logic [N_REQ-1:0]         o_Grant;
    logic                     o_Busy;
    logic [6:0]               o_Segment1;
    logic [6:0]               o_Segment2;

    // Requester side: drives requests and values, observes the display.
    modport master (
        output i_Req, i_Value,
        input  o_Ack, o_Grant, o_Busy, o_Segment1, o_Segment2
    );

    // Scheduler side.
    modport slave (
        input  i_Req, i_Value,
        output o_Ack, o_Grant, o_Busy, o_Segment1, o_Segment2
    );
endinterface

// File: rtl/seg_display_scheduler.sv
// Round-robin scheduler sharing a two-digit 7-segment display between requesters.
// The granted value is converted to decimal by a subtract-10 loop and held for
// HOLD_CYCLES before the next arbitration.
module seg_display_scheduler #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned VALUE_W     = 8,
    parameter int unsigned HOLD_CYCLES = 25000000
) (
    input logic                    i_Clk,
    input logic                    i_Reset,
    seg_display_scheduler_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(N_REQ);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);

    localparam logic [6:0]       SegBlank = 7'b1111111;
    localparam logic [6:0]       SegDash  = 7'b0111111;
    localparam logic [N_REQ-1:0] OneLsb   = N_REQ'(1);

    typedef enum logic [1:0] {StIdle, StConv, StShow} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [VALUE_W-1:0] rem_q, rem_d;
    logic [3:0]         tens_q, tens_d;
    logic               big_q, big_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               busy_q, busy_d;
    logic [6:0]         seg1_q, seg1_d;
    logic [6:0]         seg2_q, seg2_d;

    logic               sel_valid;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W-1:0]   cand;
    logic [VALUE_W-1:0] sel_value;
    logic               hold_last;
    logic               rem_small;

    function automatic logic [PTR_W-1:0] wrap_idx(input int unsigned a);
        return PTR_W'(a % N_REQ);
    endfunction

    // Active-low {g,f,e,d,c,b,a}; anything out of range shows a dash.
    function automatic logic [6:0] digit_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SegDash;
        endcase
    endfunction

    assign sel_value = bus.i_Value[32'(sel_idx) * VALUE_W +: VALUE_W];
    assign hold_last = (hold_q == HOLD_W'(HOLD_CYCLES - 1));
    assign rem_small = (rem_q < VALUE_W'(10));

    // Round-robin search: first asserted request at or above the pointer, wrapping.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            cand = wrap_idx(32'(ptr_q) + 32'(i));
            if (!sel_valid && bus.i_Req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // State and all registered outputs; reset aborts any conversion or hold.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            rem_q   <= '0;
            tens_q  <= '0;
            big_q   <= 1'b0;
            hold_q  <= '0;
            ack_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            seg1_q  <= SegBlank;
            seg2_q  <= SegBlank;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            tens_q  <= tens_d;
            big_q   <= big_d;
            hold_q  <= hold_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            seg1_q  <= seg1_d;
            seg2_q  <= seg2_d;
        end
    end

    // Next-state: conversion ends once the remainder is a single digit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (sel_valid) state_d = StConv;
            StConv:  if (big_q || rem_small) state_d = StShow;
            StShow:  if (hold_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath: latch on grant, subtract-10 loop, hold counter.
    always_comb begin
        ptr_d  = ptr_q;
        rem_d  = rem_q;
        tens_d = tens_q;
        big_d  = big_q;
        hold_d = hold_q;
        case (state_q)
            StIdle: begin
                if (sel_valid) begin
                    rem_d  = sel_value;
                    tens_d = '0;
                    big_d  = (32'(sel_value) >= 32'd100);
                    ptr_d  = wrap_idx(32'(sel_idx) + 32'd1);
                end
            end
            StConv: begin
                if (!big_q && !rem_small) begin
                    rem_d  = rem_q - VALUE_W'(10);
                    tens_d = tens_q + 4'd1;
                end else begin
                    hold_d = '0;
                end
            end
            StShow: begin
                if (!hold_last) hold_d = hold_q + HOLD_W'(1);
            end
            default: ;
        endcase
    end

    // Output next-values: ack pulses on the latch edge, segments update when
    // conversion finishes, grant drops as the hold expires.
    always_comb begin
        ack_d   = '0;
        grant_d = grant_q;
        busy_d  = (state_d != StIdle);
        seg1_d  = seg1_q;
        seg2_d  = seg2_q;
        case (state_q)
            StIdle: begin
                if (sel_valid) begin
                    ack_d   = OneLsb << sel_idx;
                    grant_d = OneLsb << sel_idx;
                end
            end
            StConv: begin
                if (big_q) begin
                    seg1_d = SegDash;
                    seg2_d = SegDash;
                end else if (rem_small) begin
                    seg1_d = digit_code(tens_q);
                    seg2_d = digit_code(rem_q[3:0]);
                end
            end
            StShow: begin
                if (hold_last) grant_d = '0;
            end
            default: ;
        endcase
    end

    assign bus.o_Ack      = ack_q;
    assign bus.o_Grant    = grant_q;
    assign bus.o_Busy     = busy_q;
    assign bus.o_Segment1 = seg1_q;
    assign bus.o_Segment2 = seg2_q;
endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler: directed vectors, multi-cycle sequences and
// a randomized run against a transaction-level model.
module tb_seg_display_scheduler;
    localparam int N  = 4;
    localparam int VW = 8;
    localparam int H  = 8;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seg_display_scheduler_if #(.N_REQ(N), .VALUE_W(VW)) bus ();

    seg_display_scheduler #(
        .N_REQ(N),
        .VALUE_W(VW),
        .HOLD_CYCLES(H)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] req;
        int         k;
        int         value;
        logic [6:0] s1;
        logic [6:0] s2;
        int         conv;
    } vec_t;

    vec_t vecs[6];

    // Reference model state (cycle-level view of grant transactions).
    int         m_left, m_delay, m_ptr;
    logic [3:0] m_ack, m_grant;
    logic [6:0] m_s1, m_s2, m_p1, m_p2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    function automatic logic [6:0] code(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return DASH;
        endcase
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.i_Req = '0;
        steps(n);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input string name, output logic [3:0] a);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.o_Ack == 4'b0 && n < 60);
        a = bus.o_Ack;
        if (a == 4'b0) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.o_Busy && n < 100) begin
            step();
            n++;
        end
        if (bus.o_Busy) check({name, "_idle_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic model_edge(input logic [3:0] req, input logic [31:0] val);
        bit found;
        int k, v, conv;
        m_ack = '0;
        if (m_left == 0) begin
            if (req != 4'b0) begin
                found = 1'b0;
                k = 0;
                for (int i = 0; i < N; i++) begin
                    if (!found && req[(m_ptr + i) % N]) begin
                        found = 1'b1;
                        k = (m_ptr + i) % N;
                    end
                end
                v       = int'(val[k*VW +: VW]);
                conv    = (v >= 100) ? 1 : v / 10 + 1;
                m_ack   = 4'(1) << k;
                m_grant = m_ack;
                m_ptr   = (k + 1) % N;
                m_delay = conv;
                m_left  = conv + H;
                m_p1    = (v >= 100) ? DASH : code(v / 10);
                m_p2    = (v >= 100) ? DASH : code(v % 10);
            end
        end else begin
            m_left--;
            if (m_delay > 0) begin
                m_delay--;
                if (m_delay == 0) begin
                    m_s1 = m_p1;
                    m_s2 = m_p2;
                end
            end
            if (m_left == 0) m_grant = '0;
        end
    endtask

    initial begin
        logic [3:0]  a;
        logic [3:0]  r_req;
        logic [31:0] r_val;
        int          dur;

        vecs[0] = '{4'b0010, 1, 42,  7'b0011001, 7'b0100100, 5};
        vecs[1] = '{4'b0001, 0, 0,   7'b1000000, 7'b1000000, 1};
        vecs[2] = '{4'b0001, 0, 99,  7'b0010000, 7'b0010000, 10};
        vecs[3] = '{4'b0001, 0, 150, 7'b0111111, 7'b0111111, 1};
        vecs[4] = '{4'b1000, 3, 7,   7'b1000000, 7'b1111000, 1};
        vecs[5] = '{4'b0100, 2, 100, 7'b0111111, 7'b0111111, 1};

        bus.i_Req   = '0;
        bus.i_Value = '0;

        // Reset state.
        do_reset(3);
        check("rst_seg1", 32'(bus.o_Segment1), 32'(BLANK));
        check("rst_seg2", 32'(bus.o_Segment2), 32'(BLANK));
        check("rst_grant", 32'(bus.o_Grant), 32'd0);
        check("rst_ack", 32'(bus.o_Ack), 32'd0);
        check("rst_busy", 32'(bus.o_Busy), 32'd0);

        // Single-request vectors: latency, digits, hold time.
        for (int t = 0; t < 6; t++) begin
            bus.i_Value = '0;
            bus.i_Value[vecs[t].k*VW +: VW] = vecs[t].value[7:0];
            bus.i_Req = vecs[t].req;
            step();
            check("vec_ack", 32'(bus.o_Ack), 32'(vecs[t].req));
            check("vec_grant", 32'(bus.o_Grant), 32'(vecs[t].req));
            check("vec_busy", 32'(bus.o_Busy), 32'd1);
            bus.i_Req   = '0;
            bus.i_Value = $urandom;
            if (vecs[t].conv > 1) begin
                steps(vecs[t].conv - 1);
                check("vec_ack_pulse", 32'(bus.o_Ack), 32'd0);
                check("vec_grant_conv", 32'(bus.o_Grant), 32'(vecs[t].req));
            end
            step();
            check("vec_seg1", 32'(bus.o_Segment1), 32'(vecs[t].s1));
            check("vec_seg2", 32'(bus.o_Segment2), 32'(vecs[t].s2));
            steps(H - 1);
            check("vec_hold_busy", 32'(bus.o_Busy), 32'd1);
            step();
            check("vec_end_busy", 32'(bus.o_Busy), 32'd0);
            check("vec_end_grant", 32'(bus.o_Grant), 32'd0);
            check("vec_keep_seg1", 32'(bus.o_Segment1), 32'(vecs[t].s1));
        end

        // Fairness with all requests held; each grant lasts CONV(5) + H cycles.
        do_reset(2);
        bus.i_Value = {8'd42, 8'd42, 8'd42, 8'd42};
        bus.i_Req   = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_ack("fair", a);
            check("fair_order", 32'(a), 32'(4'(1) << (g % N)));
            dur = 0;
            while (bus.o_Grant == a && a != 4'b0 && dur < 100) begin
                dur++;
                step();
            end
            check("fair_grant_len", 32'(dur), 32'(5 + H));
        end
        bus.i_Req = '0;

        // Pointer continues after the last grant.
        do_reset(2);
        bus.i_Value = {8'd5, 8'd5, 8'd5, 8'd5};
        bus.i_Req   = 4'b0100;
        wait_ack("ptr_a", a);
        check("ptr_first", 32'(a), 32'b0100);
        bus.i_Req = '0;
        wait_idle("ptr");
        bus.i_Req = 4'b0101;
        wait_ack("ptr_b", a);
        check("ptr_wrap", 32'(a), 32'b0001);
        wait_ack("ptr_c", a);
        check("ptr_next", 32'(a), 32'b0100);
        bus.i_Req = '0;

        // Reset during SHOW aborts and restarts the search at index 0.
        do_reset(2);
        bus.i_Value = {8'd0, 8'd0, 8'd57, 8'd0};
        bus.i_Req   = 4'b0010;
        wait_ack("rshow", a);
        bus.i_Req = '0;
        steps(6);
        check("rshow_seg1", 32'(bus.o_Segment1), 32'b0010010);
        check("rshow_seg2", 32'(bus.o_Segment2), 32'b1111000);
        steps(2);
        rst = 1'b1;
        step();
        check("rshow_blank1", 32'(bus.o_Segment1), 32'(BLANK));
        check("rshow_blank2", 32'(bus.o_Segment2), 32'(BLANK));
        check("rshow_grant", 32'(bus.o_Grant), 32'd0);
        check("rshow_busy", 32'(bus.o_Busy), 32'd0);
        check("rshow_ack", 32'(bus.o_Ack), 32'd0);
        rst = 1'b0;
        bus.i_Value = {8'd3, 8'd3, 8'd3, 8'd3};
        bus.i_Req   = 4'b1001;
        wait_ack("rshow_after", a);
        check("rshow_ptr0", 32'(a), 32'b0001);
        bus.i_Req = '0;

        // Randomized run against the model.
        do_reset(2);
        m_left  = 0;
        m_delay = 0;
        m_ptr   = 0;
        m_ack   = '0;
        m_grant = '0;
        m_s1    = BLANK;
        m_s2    = BLANK;
        m_p1    = BLANK;
        m_p2    = BLANK;
        for (int c = 0; c < 1500; c++) begin
            r_req = ($urandom_range(0, 9) < 3) ? 4'b0 : 4'($urandom_range(1, 15));
            for (int l = 0; l < N; l++) begin
                if ($urandom_range(0, 3) != 0) r_val[l*VW +: VW] = 8'($urandom_range(0, 99));
                else r_val[l*VW +: VW] = 8'($urandom_range(0, 255));
            end
            bus.i_Req   = r_req;
            bus.i_Value = r_val;
            step();
            model_edge(r_req, r_val);
            check("rnd_ack", 32'(bus.o_Ack), 32'(m_ack));
            check("rnd_grant", 32'(bus.o_Grant), 32'(m_grant));
            check("rnd_busy", 32'(bus.o_Busy), 32'(m_left != 0));
            check("rnd_seg1", 32'(bus.o_Segment1), 32'(m_s1));
            check("rnd_seg2", 32'(bus.o_Segment2), 32'(m_s2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Shares the two-digit 7-segment display (o_Segment1 = tens, o_Segment2 = units) between N_REQ requesters, such as lane receivers and score counters.
- A round-robin arbiter grants one requester at a time and latches its value.
- The value is converted to decimal digits iteratively (subtract-10 loop, no combinational divide).
- The result is held on the display for HOLD_CYCLES before the next arbitration.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- VALUE_W, 8, width of each requester value (4..8).
- HOLD_CYCLES, 25000000, display hold time per grant, in i_Clk cycles (>=2).

Ports:
- i_Clk  input  1  system clock.
- i_Reset  input  1  synchronous, active-high reset.
- i_Req  input  N_REQ  per-requester request, level; held until o_Ack.
- i_Value  input  N_REQ*VALUE_W  packed values; requester k occupies bits [k*VALUE_W +: VALUE_W].
- o_Ack  output  N_REQ  one-hot, one-cycle pulse; value of that requester latched.
- o_Grant  output  N_REQ  one-hot; requester currently owning the display.
- o_Busy  output  1  high whenever the state is not IDLE.
- o_Segment1  output  7  tens digit, active-low segments {g,f,e,d,c,b,a}.
- o_Segment2  output  7  units digit, same encoding.

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - State = IDLE, o_Ack = 0, o_Grant = 0, o_Busy = 0.
  - o_Segment1 = o_Segment2 = 7'b1111111 (blank).
  - Round-robin pointer = 0.
- Reset mid-operation aborts any CONV or SHOW immediately and applies the reset values. No o_Ack is issued.
- Digit codes, 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Dash = 0111111.
- FSM states: IDLE, CONV, SHOW.
- IDLE:
  - If i_Req == 0: stay in IDLE; segments keep their last value.
  - Otherwise, select the first asserted requester searching from the pointer upward, modulo N_REQ.
  - On that edge: latch its value into rem and clear tens; set o_Grant[k] and o_Ack[k]; set pointer = (k+1) mod N_REQ; go to CONV.
- o_Ack is high for exactly one cycle, the first CONV cycle. o_Grant stays high through CONV and SHOW and clears on return to IDLE.
- CONV, one step per cycle:
  - If the latched value >= 100: both segments = dash, go to SHOW in one cycle.
  - Else if rem >= 10: rem -= 10, tens += 1.
  - Else: o_Segment1 = code(tens), o_Segment2 = code(rem); hold counter cleared; go to SHOW.
  - Latency for value v < 100: the segments update floor(v/10)+1 edges after the latch edge. Worst case is 10 cycles.
- Tens is a 4-bit register; rem is VALUE_W bits wide. Values 0..9 show a leading 0 (tens = code 0, not blanked).
- SHOW: the hold counter increments each cycle. When it equals HOLD_CYCLES-1, return to IDLE. Segments stay unchanged until the next CONV completes.
- i_Req and i_Value are ignored outside IDLE. Dropping or changing them during CONV or SHOW has no effect. A request still asserted when SHOW ends is arbitrated in the next IDLE cycle.
- Minimum grant period is 1 (IDLE) + CONV cycles + HOLD_CYCLES.
- Fairness: with all requests held high, grants follow 0,1,...,N_REQ-1,0,... with no requester skipped.

Test Plan (HOLD_CYCLES=8, N_REQ=4):
- Reset held for 3 cycles, no requests -> o_Segment1 = o_Segment2 = 1111111; o_Grant = 0; o_Ack = 0; o_Busy = 0.
- i_Req = 0010 with value 42 -> o_Ack = 0010 for one cycle; o_Grant = 0010. Five edges after the latch edge: o_Segment1 = 0011001, o_Segment2 = 0100100. Held for 8 cycles, then o_Busy = 0.
- Boundary values on requester 0: value 0 -> 1000000/1000000 after 1 CONV cycle; 99 -> 0010000/0010000 after 10 CONV cycles; 150 -> 0111111/0111111 after 1 CONV cycle.
- i_Req = 1111 held continuously -> o_Ack order is 0001, 0010, 0100, 1000, 0001. Each o_Grant lasts exactly CONV + 8 cycles.
- Pointer check: grant requester 2, then i_Req = 0101 -> requester 0 is granted (search 3, 0). Then with i_Req = 0101 -> requester 2 is granted.
- Reset asserted during SHOW of value 57 -> next edge: segments blank, o_Grant = 0, o_Busy = 0. The first request afterwards is searched from index 0.
